// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
// Shares the single 64-bit DDR3 read port between NUM_REQ word-read requesters.
// Requester 0 (apu sample fetcher) can optionally override round-robin order.
// One read is outstanding at a time; a watchdog aborts an unacknowledged read.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester request pending (held until req_grant)
//   req_addr     per-requester 29-bit word address, requester i at [29*i +: 29]
//   req_grant    one-hot 1-cycle pulse: request accepted
//   rsp_valid    one-hot 1-cycle pulse: rsp_data valid for that requester
//   rsp_err      one-hot 1-cycle pulse: read timed out
//   rsp_data     latched read data, holds between responses
//   mem_addr     DDR3 word address
//   mem_read_en  DDR3 read strobe, held with stable mem_addr until ack/timeout
//   mem_data     DDR3 read data, valid with mem_ack
//   mem_ack      DDR3 data valid strobe
//   busy         high while a read is outstanding
// -----------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PRIO0   = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*29-1:0]  req_addr,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [NUM_REQ-1:0]     rsp_err,
    output logic [63:0]            rsp_data,
    output logic [28:0]            mem_addr,
    output logic                   mem_read_en,
    input  logic [63:0]            mem_data,
    input  logic                   mem_ack,
    output logic                   busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               state_r;
    logic [PTR_W-1:0]     rr_ptr_r;
    logic [PTR_W-1:0]     cur_r;
    logic [WD_W-1:0]      watchdog_r;

    logic [PTR_W-1:0]     win_s;
    logic [PTR_W:0]       sum_s;
    logic [PTR_W:0]       idx_s;
    logic [PTR_W-1:0]     next_ptr_s;
    logic [NUM_REQ-1:0]   win_oh_s;
    logic [NUM_REQ-1:0]   cur_oh_s;
    logic [28:0]          win_addr_s;
    logic                 any_valid_s;
    logic                 timeout_s;

    // Winner selection: scan offsets from highest to lowest so the lowest
    // offset from rr_ptr that is valid is the final value; then apply the
    // requester-0 override.
    always_comb begin
        win_s = '0;
        sum_s = '0;
        idx_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
            idx_s = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? (sum_s - (PTR_W+1)'(NUM_REQ)) : sum_s;
            win_s = req_valid[idx_s[PTR_W-1:0]] ? idx_s[PTR_W-1:0] : win_s;
        end
        win_s = ((PRIO0 != 0) && req_valid[0]) ? '0 : win_s;
    end

    // One-hot decodes of the winner and the in-flight requester, plus address mux
    always_comb begin
        win_oh_s   = '0;
        cur_oh_s   = '0;
        win_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_oh_s[i] = (win_s == PTR_W'(i));
            cur_oh_s[i] = (cur_r == PTR_W'(i));
            win_addr_s  = (win_s == PTR_W'(i)) ? req_addr[29*i +: 29] : win_addr_s;
        end
    end

    // Round-robin pointer advance and watchdog expiry
    always_comb begin
        next_ptr_s  = (win_s == PTR_W'(NUM_REQ - 1)) ? '0 : (win_s + PTR_W'(1));
        any_valid_s = |req_valid;
        timeout_s   = (watchdog_r == WD_W'(TIMEOUT - 1));
    end

    // Arbiter FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            cur_r       <= '0;
            watchdog_r  <= '0;
            req_grant   <= '0;
            rsp_valid   <= '0;
            rsp_err     <= '0;
            rsp_data    <= '0;
            mem_addr    <= '0;
            mem_read_en <= 1'b0;
            busy        <= 1'b0;
        end else begin
            req_grant <= '0;
            rsp_valid <= '0;
            rsp_err   <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        req_grant   <= win_oh_s;
                        mem_addr    <= win_addr_s;
                        mem_read_en <= 1'b1;
                        busy        <= 1'b1;
                        cur_r       <= win_s;
                        rr_ptr_r    <= next_ptr_s;
                        watchdog_r  <= '0;
                        state_r     <= ST_WAIT;
                    end else begin
                        mem_read_en <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Ack takes precedence over a coincident timeout
                    if (mem_ack && mem_read_en) begin
                        rsp_valid   <= cur_oh_s;
                        rsp_data    <= mem_data;
                        mem_read_en <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (timeout_s) begin
                        rsp_err     <= cur_oh_s;
                        mem_read_en <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        watchdog_r  <= watchdog_r + WD_W'(1);
                        state_r     <= ST_WAIT;
                    end
                end
                default: begin
                    mem_read_en <= 1'b0;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
